openofdm_rx_ctrl: RTL
=====================

Name: openofdm_rx_ctrl

Overview:
Packet-level sequencer and watchdog for the dot11 receive core. Tracks each reception through short preamble, long preamble, header and payload/FCS using dot11 status outputs. Aborts stalled or illegal receptions by pulsing a core reset, which the wrapper ORs into the dot11 reset. Sits in openofdm_rx beside dot11; timeouts are programmed from slv_regs.

Parameters:
TIMER_WIDTH, 16, width of the watchdog timer and of every timeout field
RST_LEN_WIDTH, 4, width of the reset pulse length field

Ports:
clock  in  1  single clock; all logic sampled on its rising edge
reset  in  1  synchronous, active-high reset
ctrl_enable  in  1  0 forces IDLE and disables all aborts
preamble_timeout  in  TIMER_WIDTH  max cycles from short to long preamble; 0 disables the check
header_timeout  in  TIMER_WIDTH  max cycles from long preamble to header strobe; 0 disables
byte_timeout  in  TIMER_WIDTH  max cycles between payload bytes; 0 disables
rst_pulse_len  in  RST_LEN_WIDTH  core_rst high time = rst_pulse_len+1 cycles
short_preamble_detected, long_preamble_detected  in  1  pulses from dot11
pkt_header_valid_strobe, pkt_header_valid, ht_unsupport  in  1  header status from dot11
pkt_len  in  16  payload length in bytes, sampled on pkt_header_valid_strobe
byte_out_strobe  in  1  payload byte valid
byte_count  in  16  dot11 running byte count
fcs_out_strobe, fcs_ok  in  1  end-of-packet FCS result
core_rst  out  1  reset request to dot11
rx_busy  out  1  high in any state other than IDLE
state  out  3  current FSM state encoding
abort_strobe  out  1  one-cycle pulse on abort
abort_cause  out  3  cause of the last abort; held until the next abort
pkt_done_strobe  out  1  one-cycle pulse at packet end
pkt_fcs_ok  out  1  FCS result latched with pkt_done_strobe

Behaviour:
- Reset values: state=IDLE(0), core_rst=0, rx_busy=0, abort_strobe=0, abort_cause=0, pkt_done_strobe=0, pkt_fcs_ok=0, timer=0, latched length=0.
- All outputs are registered. Each responds one cycle after the triggering input.
- Timer: clears on every state entry, then increments each cycle and saturates at all-ones. Timeout fires when a timeout field is nonzero and timer == field-1, so the abort occurs exactly N cycles after state entry.
- State encodings: IDLE=0, WAIT_LONG=1, WAIT_HDR=2, PAYLOAD=3, RESET=4.
- IDLE: short_preamble_detected -> WAIT_LONG.
- WAIT_LONG: long_preamble_detected -> WAIT_HDR. Timeout -> abort, cause 1.
- WAIT_HDR: on pkt_header_valid_strobe:
  - valid & ~ht_unsupport & pkt_len!=0 -> PAYLOAD, latch pkt_len.
  - ~valid -> abort, cause 2.
  - ht_unsupport -> abort, cause 3.
  - pkt_len==0 -> abort, cause 2.
  - Timeout -> abort, cause 4.
- PAYLOAD:
  - byte_out_strobe clears the timer.
  - fcs_out_strobe -> pulse pkt_done_strobe, latch pkt_fcs_ok=fcs_ok, go to IDLE.
  - byte_count > latched length -> abort, cause 6.
  - Byte timeout -> abort, cause 5.
- Abort: pulse abort_strobe, update abort_cause, enter RESET.
- RESET: core_rst=1 for rst_pulse_len+1 cycles, then core_rst=0 and return to IDLE. All dot11 inputs are ignored while in RESET.
- Simultaneous-event priority: fcs_out_strobe > overrun > byte timeout. Header strobe beats header timeout. long_preamble_detected beats preamble timeout.
- ctrl_enable=0 takes effect the next cycle: IDLE, core_rst=0, timer=0. Strobes are suppressed; abort_cause and pkt_fcs_ok hold their values. If ctrl_enable drops during RESET, core_rst is released immediately.
- Reset asserted in any state: all registers return to reset values on the next edge, including mid-packet.

Optional Feature:
OPENOFDM_RX_CTRL_STATS_EN.
- Defined: adds input stats_clr and outputs pkt_ok_cnt[15:0], pkt_fail_cnt[15:0], abort_cnt[15:0].
- Counters are saturating and increment on pkt_done_strobe with FCS ok, pkt_done_strobe with FCS fail, and abort_strobe respectively.
- stats_clr or reset zeroes all counters; clear beats increment in the same cycle.
- Undefined: these ports are absent and no counter logic is built.

Decomposition:
- Package openofdm_rx_ctrl_pkg holds the state enum (IDLE..RESET) and the abort cause constants: CAUSE_NONE=0, PREAMBLE_TO=1, HDR_BAD=2, HT_UNSUP=3, HDR_TO=4, BYTE_TO=5, OVERRUN=6.
- One sub-module, openofdm_rx_ctrl_wdog, contains the timer, clear and compare logic for the timeout check.

Test Plan:
- Normal packet: short, long after 200 cycles, header valid with pkt_len=100, 100 bytes at 20-cycle spacing, fcs_ok=1 -> pkt_done_strobe once, pkt_fcs_ok=1, state returns to 0, no abort.
- preamble_timeout=160, no long preamble -> abort_strobe exactly 160 cycles after WAIT_LONG entry, cause 1. With rst_pulse_len=3, core_rst is high for 4 cycles.
- Header strobe with ht_unsupport=1 -> cause 3. Header with pkt_header_valid=0 -> cause 2. header_timeout=0 with no header -> waits indefinitely.
- Payload with byte_timeout=50 and bytes stopping after byte 10 -> cause 5. byte_count=101 with pkt_len=100 -> cause 6.
- fcs_out_strobe in the same cycle as the byte timeout -> pkt_done_strobe fires, no abort.
- reset mid-PAYLOAD, then ctrl_enable=0 during RESET -> all outputs return to reset values and core_rst is released the next cycle. With STATS_EN, verify counts ok=1, fail=0, aborts=N, and that stats_clr zeroes them.

Source files
------------

// File: rtl/openofdm_rx_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : openofdm_rx_ctrl_pkg
// Brief    : State encoding and abort-cause codes shared by the receive
//            sequencer and its watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package openofdm_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LONG = 3'd1,
    WAIT_HDR  = 3'd2,
    PAYLOAD   = 3'd3,
    RESET     = 3'd4
  } state_t;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] PREAMBLE_TO = 3'd1;
  localparam logic [2:0] HDR_BAD     = 3'd2;
  localparam logic [2:0] HT_UNSUP    = 3'd3;
  localparam logic [2:0] HDR_TO      = 3'd4;
  localparam logic [2:0] BYTE_TO     = 3'd5;
  localparam logic [2:0] OVERRUN     = 3'd6;

endpackage
`default_nettype wire

// File: rtl/openofdm_rx_ctrl_wdog.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : openofdm_rx_ctrl_wdog
// Brief    : Saturating watchdog timer. Cleared by the sequencer on state
//            entry (and on payload bytes); flags expiry when a nonzero
//            timeout field equals timer+1, so the abort registered on the
//            following edge lands exactly N cycles after the clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module openofdm_rx_ctrl_wdog #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [TIMER_WIDTH-1:0] timeout,
  output logic [TIMER_WIDTH-1:0] timer,
  output logic                   expired
);

  // Timer: zero on clear, otherwise count up and hold at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + TIMER_WIDTH'(1);
    end
  end

  // A zero field disables the check entirely.
  assign expired = (timeout != '0) && (timer == (timeout - TIMER_WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/openofdm_rx_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : openofdm_rx_ctrl
// Brief    : Packet-level sequencer and watchdog for the dot11 receive core.
//            Follows short preamble -> long preamble -> header -> payload/FCS
//            and pulses core_rst to abort stalled or illegal receptions.
//            Optional statistics counters: define OPENOFDM_RX_CTRL_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module openofdm_rx_ctrl
  import openofdm_rx_ctrl_pkg::*;
#(
  parameter int TIMER_WIDTH   = 16,
  parameter int RST_LEN_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ctrl_enable,
  input  logic [TIMER_WIDTH-1:0]   preamble_timeout,
  input  logic [TIMER_WIDTH-1:0]   header_timeout,
  input  logic [TIMER_WIDTH-1:0]   byte_timeout,
  input  logic [RST_LEN_WIDTH-1:0] rst_pulse_len,
  input  logic                     short_preamble_detected,
  input  logic                     long_preamble_detected,
  input  logic                     pkt_header_valid_strobe,
  input  logic                     pkt_header_valid,
  input  logic                     ht_unsupport,
  input  logic [15:0]              pkt_len,
  input  logic                     byte_out_strobe,
  input  logic [15:0]              byte_count,
  input  logic                     fcs_out_strobe,
  input  logic                     fcs_ok,
  output logic                     core_rst,
  output logic                     rx_busy,
  output logic [2:0]               state,
  output logic                     abort_strobe,
  output logic [2:0]               abort_cause,
  output logic                     pkt_done_strobe,
  output logic                     pkt_fcs_ok
`ifdef OPENOFDM_RX_CTRL_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              pkt_ok_cnt,
  output logic [15:0]              pkt_fail_cnt,
  output logic [15:0]              abort_cnt
`endif
);

  state_t                   state_q, state_d;
  logic [15:0]              len_q;
  logic [TIMER_WIDTH-1:0]   timer;
  logic [TIMER_WIDTH-1:0]   timeout_sel;
  logic                     expired;
  logic                     timer_clear;
  logic                     abort;
  logic                     done;
  logic                     latch_len;
  logic [2:0]               cause_d;

  openofdm_rx_ctrl_wdog #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .timeout (timeout_sel),
    .timer   (timer),
    .expired (expired)
  );

  // Pick the timeout field that applies to the current state.
  always_comb begin
    timeout_sel = '0;
    case (state_q)
      WAIT_LONG: timeout_sel = preamble_timeout;
      WAIT_HDR:  timeout_sel = header_timeout;
      PAYLOAD:   timeout_sel = byte_timeout;
      default:   timeout_sel = '0;
    endcase
  end

  // Next state, abort decision and packet-end decision.
  always_comb begin
    state_d   = state_q;
    abort     = 1'b0;
    done      = 1'b0;
    latch_len = 1'b0;
    cause_d   = abort_cause;
    if (!ctrl_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (short_preamble_detected) state_d = WAIT_LONG;
        end
        WAIT_LONG: begin
          if (long_preamble_detected) begin
            state_d = WAIT_HDR;
          end else if (expired) begin
            abort   = 1'b1;
            cause_d = PREAMBLE_TO;
          end
        end
        WAIT_HDR: begin
          if (pkt_header_valid_strobe) begin
            if (!pkt_header_valid) begin
              abort   = 1'b1;
              cause_d = HDR_BAD;
            end else if (ht_unsupport) begin
              abort   = 1'b1;
              cause_d = HT_UNSUP;
            end else if (pkt_len == 16'd0) begin
              abort   = 1'b1;
              cause_d = HDR_BAD;
            end else begin
              state_d   = PAYLOAD;
              latch_len = 1'b1;
            end
          end else if (expired) begin
            abort   = 1'b1;
            cause_d = HDR_TO;
          end
        end
        PAYLOAD: begin
          if (fcs_out_strobe) begin
            done    = 1'b1;
            state_d = IDLE;
          end else if (byte_count > len_q) begin
            abort   = 1'b1;
            cause_d = OVERRUN;
          end else if (expired && !byte_out_strobe) begin
            // A byte arriving on the deadline counts as on time.
            abort   = 1'b1;
            cause_d = BYTE_TO;
          end
        end
        RESET: begin
          // Timer was cleared on entry, so this holds core_rst len+1 cycles.
          if (timer == TIMER_WIDTH'(rst_pulse_len)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (abort) state_d = RESET;
    end
  end

  // Timer restarts on every state change, on each payload byte and while disabled.
  assign timer_clear = !ctrl_enable || (state_d != state_q) ||
                       ((state_q == PAYLOAD) && byte_out_strobe);

  // Registered state and outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      core_rst        <= 1'b0;
      rx_busy         <= 1'b0;
      abort_strobe    <= 1'b0;
      abort_cause     <= CAUSE_NONE;
      pkt_done_strobe <= 1'b0;
      pkt_fcs_ok      <= 1'b0;
      len_q           <= '0;
    end else begin
      state_q         <= state_d;
      core_rst        <= (state_d == RESET);
      rx_busy         <= (state_d != IDLE);
      abort_strobe    <= abort;
      pkt_done_strobe <= done;
      if (abort)     abort_cause <= cause_d;
      if (done)      pkt_fcs_ok  <= fcs_ok;
      if (latch_len) len_q       <= pkt_len;
    end
  end

  assign state = state_q;

`ifdef OPENOFDM_RX_CTRL_STATS_EN
  // Saturating packet/abort counters; clear wins over increment.
  always_ff @(posedge clock) begin
    if (reset || stats_clr) begin
      pkt_ok_cnt   <= '0;
      pkt_fail_cnt <= '0;
      abort_cnt    <= '0;
    end else begin
      if (pkt_done_strobe && pkt_fcs_ok && (pkt_ok_cnt != '1))
        pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
      if (pkt_done_strobe && !pkt_fcs_ok && (pkt_fail_cnt != '1))
        pkt_fail_cnt <= pkt_fail_cnt + 16'd1;
      if (abort_strobe && (abort_cnt != '1))
        abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
